// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic [3:0] bytes_of(size_e sz);
    return 4'(4'd1 << sz);
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed bytes out of a word pair and sign/zero-extends them to XLEN.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned OFF_W = $clog2(XLEN / 8),
  localparam int unsigned BIT_W = $clog2(XLEN)
) (
  input  logic [XLEN-1:0]  lo_word_i,
  input  logic [XLEN-1:0]  hi_word_i,
  input  logic [OFF_W-1:0] offset_i,
  input  size_e            size_i,
  input  logic             unsigned_i,
  output logic [XLEN-1:0]  data_o
);

  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] mask;
  int unsigned     nbits;

  always_comb begin
    raw   = XLEN'({hi_word_i, lo_word_i} >> {offset_i, 3'b000});
    nbits = 8 * bytes_of(size_i);
    if (nbits > XLEN) nbits = XLEN;
    mask   = {XLEN{1'b1}} >> (XLEN - nbits);
    data_o = raw & mask;
    // A full-width load has an empty ~mask, so the extension mode is moot there
    if (!unsigned_i && raw[BIT_W'(nbits - 1)]) data_o = data_o | ~mask;
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable little-endian data RAM behind a valid/ready request/response
// handshake; word-crossing accesses are split into two word cycles.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       split_cnt
);

  localparam int unsigned WB     = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(WB);
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;
  localparam int unsigned NWORDS = 2 ** IDX_W;
  localparam int unsigned EW     = ADDR_W + 2;
  localparam int unsigned DW     = 2 * XLEN;
  localparam int unsigned DB     = 2 * WB;

  logic [XLEN-1:0] mem [NWORDS];

  state_e            state_q, state_d;
  logic              ready_q, rsp_valid_q, rsp_err_q;
  logic              we_q, uns_q, err_q;
  size_e             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   word0_q, word1_q;
  logic [15:0]       split_q;

  logic              accept_c, req_err_c, cross_c;
  size_e             req_sz_c;
  logic [OFF_W-1:0]  off_c;
  logic [IDX_W-1:0]  idx0_c, idx1_c;
  logic [DW-1:0]     wide_data_c;
  logic [DB-1:0]     wide_be_c;
  logic [XLEN-1:0]   ld_data_c;

  // Request decode: range/size errors are resolved before any array access
  always_comb begin
    req_sz_c  = size_e'(req_size);
    accept_c  = ready_q && req_valid && (state_q == ST_IDLE);
    req_err_c = ((EW'(req_addr) + EW'(bytes_of(req_sz_c))) > EW'(2 ** ADDR_W))
             || ((req_sz_c == SZ_D) && (XLEN < 64));
  end

  // Latched-request geometry: word indices, crossing, and store lanes over a word pair
  always_comb begin
    off_c       = addr_q[OFF_W-1:0];
    idx0_c      = addr_q[ADDR_W-1:OFF_W];
    idx1_c      = IDX_W'(idx0_c + 1'b1);
    cross_c     = (5'(off_c) + 5'(bytes_of(size_q))) > 5'(WB);
    wide_data_c = DW'(wdata_q) << {off_c, 3'b000};
    wide_be_c   = DB'((16'd1 << bytes_of(size_q)) - 16'd1) << off_c;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = req_err_c ? ST_RESP : ST_ACC0;
      ST_ACC0: state_d = cross_c ? ST_ACC1 : ST_RESP;
      ST_ACC1: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= SZ_B;
      addr_q      <= '0;
      wdata_q     <= '0;
      split_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      rsp_err_q   <= (state_d == ST_RESP) && (accept_c ? req_err_c : err_q);
      if (accept_c) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err_c;
        size_q  <= req_sz_c;
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
      end
      if ((state_q == ST_ACC1) && (split_q != 16'hFFFF)) split_q <= split_q + 16'd1;
    end
  end

  // Single-port array: exactly one word read/written per access state
  always_ff @(posedge clk) begin
    if (state_q == ST_ACC0) begin
      word0_q <= mem[idx0_c];
      if (we_q) begin
        for (int b = 0; b < WB; b++) begin
          if (wide_be_c[b]) mem[idx0_c][8*b +: 8] <= wide_data_c[8*b +: 8];
        end
      end
    end
    if (state_q == ST_ACC1) begin
      word1_q <= mem[idx1_c];
      if (we_q) begin
        for (int b = 0; b < WB; b++) begin
          if (wide_be_c[WB+b]) mem[idx1_c][8*b +: 8] <= wide_data_c[XLEN+8*b +: 8];
        end
      end
    end
  end

  dmem_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .lo_word_i (word0_q),
    .hi_word_i (word1_q),
    .offset_i  (off_c),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .data_o    (ld_data_c)
  );

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && !we_q && !err_q) ? ld_data_c : '0;
  assign split_cnt = split_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed-vector bench for data_memory_ctrl (XLEN=32, ADDR_W=12).
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] split_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  data_memory_ctrl #(
    .XLEN(32),
    .ADDR_W(12),
    .INIT_FILE("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .split_cnt   (split_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Latency counts rising edges from the accept edge (inclusive) to rsp_valid high
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [12:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [12:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(we, sz, uns, addr, wd, rd, er, lat);
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    check({tag, "_err"}, 64'(er), 64'(exp_er));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_split", 64'(split_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Aligned word, byte and half accesses
    access("st_w0", 1'b1, 2'd2, 1'b0, 13'h000, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    access("ld_w0", 1'b0, 2'd2, 1'b0, 13'h000, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    access("st_w4", 1'b1, 2'd2, 1'b0, 13'h004, 32'h00000000, 32'h0, 1'b0, 2);
    access("st_b4", 1'b1, 2'd0, 1'b0, 13'h004, 32'h123456FF, 32'h0, 1'b0, 2);
    access("ld_b4s", 1'b0, 2'd0, 1'b0, 13'h004, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    access("ld_b4u", 1'b0, 2'd0, 1'b1, 13'h004, 32'h0, 32'h000000FF, 1'b0, 2);
    access("ld_w4", 1'b0, 2'd2, 1'b0, 13'h004, 32'h0, 32'h000000FF, 1'b0, 2);
    access("st_h8", 1'b1, 2'd1, 1'b0, 13'h008, 32'hCAFE8001, 32'h0, 1'b0, 2);
    access("ld_h8s", 1'b0, 2'd1, 1'b0, 13'h008, 32'h0, 32'hFFFF8001, 1'b0, 2);
    access("ld_h8u", 1'b0, 2'd1, 1'b1, 13'h008, 32'h0, 32'h00008001, 1'b0, 2);

    // Within-word misaligned
    access("st_wC", 1'b1, 2'd2, 1'b0, 13'h00C, 32'h12345678, 32'h0, 1'b0, 2);
    access("ld_bC", 1'b0, 2'd0, 1'b0, 13'h00C, 32'h0, 32'h00000078, 1'b0, 2);
    access("ld_bD", 1'b0, 2'd0, 1'b0, 13'h00D, 32'h0, 32'h00000056, 1'b0, 2);
    access("ld_hD", 1'b0, 2'd1, 1'b1, 13'h00D, 32'h0, 32'h00003456, 1'b0, 2);
    check("split_none", 64'(split_cnt), 64'd0);

    // Word-crossing accesses
    access("st_w10", 1'b1, 2'd2, 1'b0, 13'h010, 32'h11223344, 32'h0, 1'b0, 2);
    access("st_w14", 1'b1, 2'd2, 1'b0, 13'h014, 32'h55667788, 32'h0, 1'b0, 2);
    access("st_w12", 1'b1, 2'd2, 1'b0, 13'h012, 32'hAABBCCDD, 32'h0, 1'b0, 3);
    access("ld_w12", 1'b0, 2'd2, 1'b0, 13'h012, 32'h0, 32'hAABBCCDD, 1'b0, 3);
    check("split_two", 64'(split_cnt), 64'd2);
    access("ld_h10", 1'b0, 2'd1, 1'b1, 13'h010, 32'h0, 32'h00003344, 1'b0, 2);
    access("ld_w14", 1'b0, 2'd2, 1'b0, 13'h014, 32'h0, 32'h5566AABB, 1'b0, 2);
    access("ld_h13", 1'b0, 2'd1, 1'b0, 13'h013, 32'h0, 32'hFFFFBBCC, 1'b0, 3);
    check("split_three", 64'(split_cnt), 64'd3);
    access("ld_b12", 1'b0, 2'd0, 1'b0, 13'h012, 32'h0, 32'hFFFFFFDD, 1'b0, 2);

    // Range and size boundaries
    access("ld_wFFE", 1'b0, 2'd2, 1'b0, 13'hFFE, 32'h0, 32'h0, 1'b1, 1);
    access("st_wFFC", 1'b1, 2'd2, 1'b0, 13'hFFC, 32'hA5A55A5A, 32'h0, 1'b0, 2);
    access("ld_wFFC", 1'b0, 2'd2, 1'b0, 13'hFFC, 32'h0, 32'hA5A55A5A, 1'b0, 2);
    access("ld_hFFF", 1'b0, 2'd1, 1'b0, 13'hFFF, 32'h0, 32'h0, 1'b1, 1);
    access("ld_bFFF", 1'b0, 2'd0, 1'b0, 13'hFFF, 32'h0, 32'hFFFFFFA5, 1'b0, 2);
    access("st_w1000", 1'b1, 2'd2, 1'b0, 13'h1000, 32'h01020304, 32'h0, 1'b1, 1);
    access("ld_w0_post", 1'b0, 2'd2, 1'b0, 13'h000, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    access("ld_d0", 1'b0, 2'd3, 1'b0, 13'h000, 32'h0, 32'h0, 1'b1, 1);
    access("st_d0", 1'b1, 2'd3, 1'b0, 13'h000, 32'h0, 32'h0, 1'b1, 1);
    access("ld_w0_sz3", 1'b0, 2'd2, 1'b0, 13'h000, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    check("split_after_err", 64'(split_cnt), 64'd3);

    // Response back-pressure: outputs hold while rsp_ready stays low
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 13'h00C; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_valid0", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_rdata", 64'(rsp_rdata), 64'h12345678);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("hold_release", 64'(rsp_valid), 64'd0);

    // Asynchronous reset while the second half of a split load is in flight
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 13'h012;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(rsp_valid), 64'd0);
    check("arst_split", 64'(split_cnt), 64'd0);
    check("arst_ready", 64'(req_ready), 64'd0);
    check("arst_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_valid", 64'(rsp_valid), 64'd0);
    access("ld_w0_rst", 1'b0, 2'd2, 1'b0, 13'h000, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    access("ld_w12_rst", 1'b0, 2'd2, 1'b0, 13'h012, 32'h0, 32'hAABBCCDD, 1'b0, 3);
    check("split_post_rst", 64'(split_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
